// File: rtl/parking_timer_tick_counter_pkg.sv
// parking_pkg: types and constants shared by the parking timer tick counter.
//   state_t                : session states IDLE, RUN, HOLD, EXP
//   SEC_MAX                : last seconds value before the minute rolls over
//   DEFAULT_TICKS_PER_SEC  : TIMER_CLK rising edges per second (100 MHz / 200000)
//   DEFAULT_MIN_W          : width of the minutes counter
//   DEFAULT_LIMIT_MIN      : minute count at which a session expires
//   pre_width()            : prescaler width for a given tick rate (never below 1)
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    EXP  = 2'd3
  } state_t;

  localparam int SEC_MAX               = 59;
  localparam int DEFAULT_TICKS_PER_SEC = 500;
  localparam int DEFAULT_MIN_W         = 8;
  localparam int DEFAULT_LIMIT_MIN     = 120;

  // A rate of one tick per second still needs a 1-bit prescaler to compare against.
  function automatic int pre_width(input int ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/parking_timer_tick_counter_if.sv
// parking_timer_tick_counter_if: control and status bundle of the parking timer.
//   START, STOP, CLEAR : session commands (master -> slave)
//   SECONDS            : 0..59 elapsed seconds
//   MINUTES            : elapsed minutes, MIN_W bits
//   RUNNING, EXPIRED   : session status flags
//   TICK_SEC           : one-cycle pulse aligned with every new SECONDS value
// Modports: master = display/billing side, slave = the tick counter.
interface parking_timer_tick_counter_if
  import parking_pkg::*;
#(
  parameter int MIN_W = DEFAULT_MIN_W
);

  logic             START;
  logic             STOP;
  logic             CLEAR;
  logic [5:0]       SECONDS;
  logic [MIN_W-1:0] MINUTES;
  logic             RUNNING;
  logic             EXPIRED;
  logic             TICK_SEC;

  modport master (
    output START, STOP, CLEAR,
    input  SECONDS, MINUTES, RUNNING, EXPIRED, TICK_SEC
  );

  modport slave (
    input  START, STOP, CLEAR,
    output SECONDS, MINUTES, RUNNING, EXPIRED, TICK_SEC
  );

endinterface

// File: rtl/parking_timer_tick_counter_edge_detect.sv
// timer_edge_detect: turns the divided TIMER_CLK level into a one-cycle tick
// per rising edge, entirely in the clk domain.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   timer_clk : divided square wave, treated as data
//   tick      : high for one clk cycle per rising edge of timer_clk
// Macro PARKING_TIMER_SYNC_EN adds a front flop so t_cur becomes the second
// stage of a 2-flop synchronizer (one extra cycle of latency).
module timer_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic timer_clk,
  output logic tick
);

  logic stage_in;
  logic t_cur;
  logic t_prev;

`ifdef PARKING_TIMER_SYNC_EN
  logic sync_ff;

  // First synchronizer flop; t_cur below is the second.
  always_ff @(posedge clk) begin
    if (rst) sync_ff <= 1'b0;
    else     sync_ff <= timer_clk;
  end

  assign stage_in = sync_ff;
`else
  assign stage_in = timer_clk;
`endif

  // t_prev keeps tracking even when the counter ignores ticks, so resuming
  // never produces a phantom edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_cur  <= 1'b0;
      t_prev <= 1'b0;
    end else begin
      t_cur  <= stage_in;
      t_prev <= t_cur;
    end
  end

  assign tick = t_cur & ~t_prev;

endmodule

// File: rtl/parking_timer_tick_counter.sv
// parking_timer_tick_counter: accumulates parking time in MM:SS from the
// rising edges of the divided TIMER_CLK, under START/STOP/CLEAR control.
//   CLK_IN    : system clock (only clock of the block)
//   RST       : synchronous active-high reset
//   TIMER_CLK : divided square wave, sampled as data
//   bus       : slave side of parking_timer_tick_counter_if
//               (START/STOP/CLEAR in; SECONDS/MINUTES/RUNNING/EXPIRED/TICK_SEC out)
// Parameters: TICKS_PER_SEC, MIN_W, LIMIT_MIN (LIMIT_MIN < 2**MIN_W).
// Macro PARKING_TIMER_SYNC_EN: synchronize TIMER_CLK before edge detection.
module parking_timer_tick_counter
  import parking_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int MIN_W         = DEFAULT_MIN_W,
  parameter int LIMIT_MIN     = DEFAULT_LIMIT_MIN
) (
  input  logic                         CLK_IN,
  input  logic                         RST,
  input  logic                         TIMER_CLK,
  parking_timer_tick_counter_if.slave  bus
);

  localparam int               PRE_W     = pre_width(TICKS_PER_SEC);
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [5:0]       SEC_TOP   = 6'(SEC_MAX);
  localparam logic [MIN_W-1:0] MIN_LIMIT = MIN_W'(LIMIT_MIN);

  state_t           state, state_next;
  logic [PRE_W-1:0] prescaler, prescaler_next;
  logic [5:0]       seconds, seconds_next;
  logic [MIN_W-1:0] minutes, minutes_next;
  logic             tick_sec, tick_sec_next;
  logic             tick;

  timer_edge_detect u_edge (
    .clk       (CLK_IN),
    .rst       (RST),
    .timer_clk (TIMER_CLK),
    .tick      (tick)
  );

  // Next-state and counter logic. CLEAR beats STOP beats START; a tick only
  // counts when the session is already in RUN and no command is pending, so
  // ticks coinciding with START, STOP or CLEAR are dropped.
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    seconds_next   = seconds;
    minutes_next   = minutes;
    tick_sec_next  = 1'b0;

    if (bus.CLEAR) begin
      state_next     = IDLE;
      prescaler_next = '0;
      seconds_next   = '0;
      minutes_next   = '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (bus.START && !bus.STOP) state_next = RUN;
        end
        RUN: begin
          if (bus.STOP) begin
            state_next = HOLD;
          end else if (tick) begin
            if (prescaler == PRE_MAX) begin
              prescaler_next = '0;
              tick_sec_next  = 1'b1;
              if (seconds == SEC_TOP) begin
                seconds_next = '0;
                minutes_next = minutes + 1'b1;
                // Leave RUN on the same edge that lands on LIMIT:00 so no
                // further tick can move the frozen count.
                if (minutes_next == MIN_LIMIT) state_next = EXP;
              end else begin
                seconds_next = seconds + 6'd1;
              end
            end else begin
              prescaler_next = prescaler + 1'b1;
            end
          end
        end
        EXP: begin
          state_next = EXP;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and counter registers; TICK_SEC is registered so it lines up with
  // the SECONDS value it announces.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state     <= IDLE;
      prescaler <= '0;
      seconds   <= '0;
      minutes   <= '0;
      tick_sec  <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      seconds   <= seconds_next;
      minutes   <= minutes_next;
      tick_sec  <= tick_sec_next;
    end
  end

  assign bus.SECONDS  = seconds;
  assign bus.MINUTES  = minutes;
  assign bus.RUNNING  = (state == RUN);
  assign bus.EXPIRED  = (state == EXP);
  assign bus.TICK_SEC = tick_sec;

endmodule

// File: tb/tb_parking_timer_tick_counter.sv
// tb_parking_timer_tick_counter: directed bench for parking_timer_tick_counter
// with TICKS_PER_SEC=4, LIMIT_MIN=2 and an 8-cycle TIMER_CLK. A tick-count
// model is compared with the DUT every cycle; literal checks pin the model.
// Honours PARKING_TIMER_SYNC_EN for the expected edge latency.
module tb_parking_timer_tick_counter;
  import parking_pkg::*;

  localparam int TPS       = 4;
  localparam int LIMIT     = 2;
  localparam int MW        = 8;
`ifdef PARKING_TIMER_SYNC_EN
  localparam int LAT       = 3;
`else
  localparam int LAT       = 2;
`endif
  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_HOLD    = 2;
  localparam int M_EXP     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timer_clk = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int ts_count = 0;
  bit check_en = 1'b0;

  // behavioural model: total counted ticks plus session mode
  int   m_total = 0;
  int   m_mode = M_IDLE;
  logic m_ts = 1'b0;
  logic tc_hist [0:3] = '{1'b0, 1'b0, 1'b0, 1'b0};

  parking_timer_tick_counter_if #(.MIN_W(MW)) bus ();

  assign bus.START = start;
  assign bus.STOP  = stop;
  assign bus.CLEAR = clear;

  parking_timer_tick_counter #(
    .TICKS_PER_SEC (TPS),
    .MIN_W         (MW),
    .LIMIT_MIN     (LIMIT)
  ) dut (
    .CLK_IN    (clk),
    .RST       (rst),
    .TIMER_CLK (timer_clk),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One-cycle command pulse, driven on the falling edge.
  task automatic applyStimulus(input logic s, input logic p, input logic c, input logic r);
    @(negedge clk);
    start = s; stop = p; clear = c; rst = r;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  task automatic runEdges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      timer_clk = 1'b1;
      repeat (4) @(negedge clk);
      timer_clk = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  // One TIMER_CLK period; reports cycles from rise to TICK_SEC (-1 if none).
  task automatic edgeWatch(output int lat, output logic [5:0] sec_at, output logic [7:0] min_at);
    lat = -1; sec_at = '1; min_at = '1;
    @(negedge clk);
    timer_clk = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) timer_clk = 1'b0;
      if (lat < 0 && bus.TICK_SEC === 1'b1) begin
        lat = c; sec_at = bus.SECONDS; min_at = bus.MINUTES;
      end
    end
  endtask

  // One TIMER_CLK period with a command held exactly across the counting edge.
  task automatic edgeWithCmd(input logic s, input logic p, input logic c);
    @(negedge clk);
    timer_clk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) timer_clk = 1'b0;
      start = (k == LAT - 1) ? s : 1'b0;
      stop  = (k == LAT - 1) ? p : 1'b0;
      clear = (k == LAT - 1) ? c : 1'b0;
    end
  endtask

  // Model step at every rising clock edge.
  initial begin
    forever begin
      @(posedge clk);
      begin
        logic tk;
        tk = tc_hist[LAT-2] & ~tc_hist[LAT-1];
        m_ts = 1'b0;
        if (rst || clear) begin
          m_total = 0;
          m_mode  = M_IDLE;
        end else if (m_mode == M_IDLE || m_mode == M_HOLD) begin
          if (start && !stop) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
          if (stop) m_mode = M_HOLD;
          else if (tk) begin
            m_total++;
            if (m_total % TPS == 0) m_ts = 1'b1;
            if (m_total == LIMIT * 60 * TPS) m_mode = M_EXP;
          end
        end
        for (int i = 3; i > 0; i--) tc_hist[i] = tc_hist[i-1];
        tc_hist[0] = timer_clk;
        if (rst) for (int i = 0; i < 4; i++) tc_hist[i] = 1'b0;
      end
    end
  end

  // Compare process: DUT against model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("model SECONDS", 32'(bus.SECONDS), 32'((m_total / TPS) % 60));
        checkOutput("model MINUTES", 32'(bus.MINUTES), 32'(m_total / (60 * TPS)));
        checkOutput("model RUNNING", 32'(bus.RUNNING), 32'(m_mode == M_RUN));
        checkOutput("model EXPIRED", 32'(bus.EXPIRED), 32'(m_mode == M_EXP));
        checkOutput("model TICK_SEC", 32'(bus.TICK_SEC), 32'(m_ts));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.TICK_SEC === 1'b1) ts_count++;
    end
  end

  initial begin
    #500000;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int ts0;
    logic [5:0] sec_at;
    logic [7:0] min_at;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    $display("[TB] reset and idle edges");
    checkOutput("reset SECONDS", 32'(bus.SECONDS), 0);
    checkOutput("reset MINUTES", 32'(bus.MINUTES), 0);
    checkOutput("reset RUNNING", 32'(bus.RUNNING), 0);
    checkOutput("reset EXPIRED", 32'(bus.EXPIRED), 0);
    checkOutput("reset TICK_SEC", 32'(bus.TICK_SEC), 0);
    runEdges(10);
    checkOutput("idle SECONDS", 32'(bus.SECONDS), 0);
    checkOutput("idle MINUTES", 32'(bus.MINUTES), 0);
    checkOutput("idle RUNNING", 32'(bus.RUNNING), 0);

    $display("[TB] first second and edge latency");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    ts0 = ts_count;
    runEdges(3);
    edgeWatch(lat, sec_at, min_at);
    checkOutput("edge latency", 32'(lat), 32'(LAT));
    checkOutput("first sec value", 32'(sec_at), 1);
    checkOutput("first sec pulses", 32'(ts_count - ts0), 1);
    checkOutput("first sec RUNNING", 32'(bus.RUNNING), 1);

    $display("[TB] minute rollover");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(239);
    checkOutput("0:59 SECONDS", 32'(bus.SECONDS), 59);
    checkOutput("0:59 MINUTES", 32'(bus.MINUTES), 0);
    edgeWatch(lat, sec_at, min_at);
    checkOutput("rollover SECONDS", 32'(sec_at), 0);
    checkOutput("rollover MINUTES", 32'(min_at), 1);

    $display("[TB] expiry and freeze");
    runEdges(240);
    checkOutput("expiry MINUTES", 32'(bus.MINUTES), 2);
    checkOutput("expiry SECONDS", 32'(bus.SECONDS), 0);
    checkOutput("expiry EXPIRED", 32'(bus.EXPIRED), 1);
    checkOutput("expiry RUNNING", 32'(bus.RUNNING), 0);
    ts0 = ts_count;
    runEdges(20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(2);
    checkOutput("frozen MINUTES", 32'(bus.MINUTES), 2);
    checkOutput("frozen SECONDS", 32'(bus.SECONDS), 0);
    checkOutput("frozen EXPIRED", 32'(bus.EXPIRED), 1);
    checkOutput("frozen pulses", 32'(ts_count - ts0), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear MINUTES", 32'(bus.MINUTES), 0);
    checkOutput("clear SECONDS", 32'(bus.SECONDS), 0);
    checkOutput("clear EXPIRED", 32'(bus.EXPIRED), 0);
    checkOutput("clear RUNNING", 32'(bus.RUNNING), 0);

    $display("[TB] prescaler kept across hold");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runEdges(8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(2);
    checkOutput("hold resume SECONDS", 32'(bus.SECONDS), 1);
    checkOutput("hold resume RUNNING", 32'(bus.RUNNING), 1);

    $display("[TB] tick collisions");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(3);
    ts0 = ts_count;
    edgeWithCmd(1'b0, 1'b1, 1'b0);
    checkOutput("stop+tick SECONDS", 32'(bus.SECONDS), 0);
    checkOutput("stop+tick RUNNING", 32'(bus.RUNNING), 0);
    checkOutput("stop+tick pulses", 32'(ts_count - ts0), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(1);
    checkOutput("after stop SECONDS", 32'(bus.SECONDS), 1);

    runEdges(3);
    ts0 = ts_count;
    edgeWithCmd(1'b0, 1'b1, 1'b1);
    checkOutput("clear+tick SECONDS", 32'(bus.SECONDS), 0);
    checkOutput("clear+tick MINUTES", 32'(bus.MINUTES), 0);
    checkOutput("clear+tick RUNNING", 32'(bus.RUNNING), 0);
    checkOutput("clear+tick pulses", 32'(ts_count - ts0), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(3);
    checkOutput("prescaler cleared", 32'(bus.SECONDS), 0);

    $display("[TB] reset mid-count");
    runEdges(3);
    checkOutput("pre-reset SECONDS", 32'(bus.SECONDS), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mid reset SECONDS", 32'(bus.SECONDS), 0);
    checkOutput("mid reset MINUTES", 32'(bus.MINUTES), 0);
    checkOutput("mid reset RUNNING", 32'(bus.RUNNING), 0);
    checkOutput("mid reset TICK_SEC", 32'(bus.TICK_SEC), 0);
    ts0 = ts_count;
    runEdges(4);
    checkOutput("post reset pulses", 32'(ts_count - ts0), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runEdges(2);
    checkOutput("post reset prescaler", 32'(bus.SECONDS), 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
